// File: rtl/fault_mem_cfg_pkg.sv
// Shared fault-class encodings and elaboration helpers for the configurable faulty memory model.
package fault_mem_cfg_pkg;

  localparam int CFG_TYPE_W = 3;

  localparam logic [CFG_TYPE_W-1:0] FT_NONE  = 3'd0;
  localparam logic [CFG_TYPE_W-1:0] FT_SAF0  = 3'd1;
  localparam logic [CFG_TYPE_W-1:0] FT_SAF1  = 3'd2;
  localparam logic [CFG_TYPE_W-1:0] FT_TF_UP = 3'd3;
  localparam logic [CFG_TYPE_W-1:0] FT_TF_DN = 3'd4;
  localparam logic [CFG_TYPE_W-1:0] FT_CFID  = 3'd5;
  localparam logic [CFG_TYPE_W-1:0] FT_NPSF  = 3'd6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fault_mem_cfg_inject.sv
// Combinational fault injector: turns one access plus the live fault config into the words to store/return.
// Zero latency; no flow control.
module fault_mem_cfg_inject
  import fault_mem_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int VBIT_W     = 3
) (
  input  logic [CFG_TYPE_W-1:0] ftype_i,
  input  logic [ADDR_WIDTH-1:0] vaddr_i,
  input  logic [ADDR_WIDTH-1:0] aaddr_i,
  input  logic [VBIT_W-1:0]     vbit_i,
  input  logic                  pol_i,
  input  logic [3:0]            pattern_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  acc_ok_i,
  input  logic                  vaddr_ok_i,
  input  logic                  write_read_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] cur_word_i,
  input  logic [DATA_WIDTH-1:0] vic_word_i,
  input  logic                  nbr_up_i,
  input  logic                  nbr_dn_i,
  output logic [DATA_WIDTH-1:0] wr_word_o,
  output logic                  victim_wr_en_o,
  output logic [DATA_WIDTH-1:0] victim_word_o,
  output logic                  rd_mask_en_o,
  output logic [DATA_WIDTH-1:0] rd_word_o,
  output logic                  hit_o
);

  logic [DATA_WIDTH-1:0] bmask;
  logic [VBIT_W-1:0]     bit_up;
  logic [VBIT_W-1:0]     bit_dn;
  logic                  on_victim;
  logic                  on_aggr;

  always_comb begin
    bmask     = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << vbit_i;
    bit_up    = (vbit_i == VBIT_W'(DATA_WIDTH-1)) ? '0 : vbit_i + 1'b1;
    bit_dn    = (vbit_i == '0) ? VBIT_W'(DATA_WIDTH-1) : vbit_i - 1'b1;
    on_victim = acc_ok_i && (address_i == vaddr_i);
    on_aggr   = acc_ok_i && (address_i == aaddr_i);

    wr_word_o      = wdata_i;
    victim_wr_en_o = 1'b0;
    victim_word_o  = vic_word_i;
    rd_mask_en_o   = 1'b0;
    rd_word_o      = cur_word_i;

    case (ftype_i)
      FT_SAF0, FT_SAF1: begin
        if (on_victim && write_read_i) begin
          wr_word_o = (ftype_i == FT_SAF1) ? (wdata_i | bmask) : (wdata_i & ~bmask);
        end else if (on_victim) begin
          rd_mask_en_o = 1'b1;
          rd_word_o    = (ftype_i == FT_SAF1) ? (cur_word_i | bmask) : (cur_word_i & ~bmask);
        end
      end
      FT_TF_UP: begin
        if (on_victim && write_read_i && !cur_word_i[vbit_i] && wdata_i[vbit_i])
          wr_word_o = wdata_i & ~bmask;
      end
      FT_TF_DN: begin
        if (on_victim && write_read_i && cur_word_i[vbit_i] && !wdata_i[vbit_i])
          wr_word_o = wdata_i | bmask;
      end
      FT_CFID: begin
        // cur_word is the aggressor's old value here, so the 0->1 edge is seen on bit b
        if (on_aggr && write_read_i && vaddr_ok_i && !cur_word_i[vbit_i] && wdata_i[vbit_i]) begin
          victim_wr_en_o = 1'b1;
          victim_word_o  = pol_i ? (vic_word_i | bmask) : (vic_word_i & ~bmask);
        end
      end
      FT_NPSF: begin
        if (on_victim && write_read_i &&
            ({nbr_up_i, nbr_dn_i, cur_word_i[bit_up], cur_word_i[bit_dn]} == pattern_i))
          wr_word_o = pol_i ? (wdata_i | bmask) : (wdata_i & ~bmask);
      end
      default: ;
    endcase

    hit_o = (wr_word_o != wdata_i) || (rd_word_o != cur_word_i) || (victim_word_o != vic_word_i);
  end

endmodule

// File: rtl/fault_mem_cfg.sv
// Single-port memory model with one runtime-selectable fault and a saturating activation counter.
// Read data 2 cycles after the read; writes store the previous cycle's wdata; no backpressure.
module fault_mem_cfg
  import fault_mem_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CAPACITY   = 64,
  parameter int CNT_WIDTH  = 8,
  localparam int VBIT_W    = clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_load,
  input  logic [CFG_TYPE_W-1:0] cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
  input  logic [VBIT_W-1:0]     cfg_vbit,
  input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
  input  logic                  cfg_pol,
  input  logic [3:0]            cfg_pattern,
  output logic [CNT_WIDTH-1:0]  fault_hits
);

  logic [DATA_WIDTH-1:0] mem_q [CAPACITY];
  logic [DATA_WIDTH-1:0] wdata_q, rd_q, rd_d, rdata_q;
  logic [CFG_TYPE_W-1:0] type_q;
  logic [ADDR_WIDTH-1:0] vaddr_q, aaddr_q;
  logic [VBIT_W-1:0]     vbit_q;
  logic                  pol_q;
  logic [3:0]            pattern_q;
  logic [CNT_WIDTH-1:0]  hits_q, hits_d;

  logic                  acc_ok, vaddr_ok, cfg_ok;
  logic [CFG_TYPE_W-1:0] ftype;
  logic [ADDR_WIDTH-1:0] vaddr_p1, vaddr_m1;
  logic [DATA_WIDTH-1:0] cur_word, vic_word, wr_word, victim_word, rd_word;
  logic                  nbr_up, nbr_dn, victim_wr_en, rd_mask_en, hit;

  always_comb begin
    acc_ok   = 32'(address) < 32'(CAPACITY);
    vaddr_ok = 32'(vaddr_q) < 32'(CAPACITY);
    cfg_ok   = (type_q <= FT_NPSF) && (32'(vbit_q) < 32'(DATA_WIDTH)) &&
               !((type_q == FT_CFID) && (aaddr_q == vaddr_q));
    ftype    = cfg_ok ? type_q : FT_NONE;
    cur_word = acc_ok ? mem_q[address] : '0;
    vic_word = vaddr_ok ? mem_q[vaddr_q] : '0;
    vaddr_p1 = vaddr_q + 1'b1;
    vaddr_m1 = vaddr_q - 1'b1;
    // Neighbours past either end of the array read as 0
    nbr_up   = (32'(vaddr_q) + 32'd1 < 32'(CAPACITY)) ? mem_q[vaddr_p1][vbit_q] : 1'b0;
    nbr_dn   = (vaddr_ok && (vaddr_q != '0)) ? mem_q[vaddr_m1][vbit_q] : 1'b0;
    rd_d     = write_read ? rd_q : (rd_mask_en ? rd_word : cur_word);
    hits_d   = (hit && (hits_q != '1)) ? hits_q + 1'b1 : hits_q;
  end

  fault_mem_cfg_inject #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .VBIT_W     (VBIT_W)
  ) u_inject (
    .ftype_i        (ftype),
    .vaddr_i        (vaddr_q),
    .aaddr_i        (aaddr_q),
    .vbit_i         (vbit_q),
    .pol_i          (pol_q),
    .pattern_i      (pattern_q),
    .address_i      (address),
    .acc_ok_i       (acc_ok),
    .vaddr_ok_i     (vaddr_ok),
    .write_read_i   (write_read),
    .wdata_i        (wdata_q),
    .cur_word_i     (cur_word),
    .vic_word_i     (vic_word),
    .nbr_up_i       (nbr_up),
    .nbr_dn_i       (nbr_dn),
    .wr_word_o      (wr_word),
    .victim_wr_en_o (victim_wr_en),
    .victim_word_o  (victim_word),
    .rd_mask_en_o   (rd_mask_en),
    .rd_word_o      (rd_word),
    .hit_o          (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q   <= '0;
      rd_q      <= '0;
      rdata_q   <= '0;
      hits_q    <= '0;
      type_q    <= FT_NONE;
      vaddr_q   <= '0;
      aaddr_q   <= '0;
      vbit_q    <= '0;
      pol_q     <= 1'b0;
      pattern_q <= '0;
    end else begin
      wdata_q <= wdata;
      rd_q    <= rd_d;
      rdata_q <= rd_q;
      hits_q  <= hits_d;
      if (cfg_load) begin
        type_q    <= cfg_type;
        vaddr_q   <= cfg_vaddr;
        aaddr_q   <= cfg_aaddr;
        vbit_q    <= cfg_vbit;
        pol_q     <= cfg_pol;
        pattern_q <= cfg_pattern;
      end
    end
  end

  // Array contents survive reset; only the access in the reset cycle is suppressed
  always_ff @(posedge clk) begin
    if (!rst && write_read && acc_ok) mem_q[address] <= wr_word;
    if (!rst && victim_wr_en)         mem_q[vaddr_q] <= victim_word;
  end

  assign rdata      = rdata_q;
  assign fault_hits = hits_q;

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Directed bench for fault_mem_cfg with a rule-level reference model checked every cycle.
module tb_fault_mem_cfg;

  localparam int CAP  = 48;
  localparam int IDLE = 40;

  logic       clk = 1'b0;
  logic       rst, write_read, cfg_load, cfg_pol;
  logic [5:0] address, cfg_vaddr, cfg_aaddr;
  logic [7:0] wdata, rdata, fault_hits;
  logic [2:0] cfg_type, cfg_vbit;
  logic [3:0] cfg_pattern;

  fault_mem_cfg #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (6),
    .CAPACITY   (CAP),
    .CNT_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_read  (write_read),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .cfg_load    (cfg_load),
    .cfg_type    (cfg_type),
    .cfg_vaddr   (cfg_vaddr),
    .cfg_vbit    (cfg_vbit),
    .cfg_aaddr   (cfg_aaddr),
    .cfg_pol     (cfg_pol),
    .cfg_pattern (cfg_pattern),
    .fault_hits  (fault_hits)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0] m_mem [CAP];
  logic [7:0] m_wprev, m_rd1, m_rdata;
  int         m_hits, m_type, m_vaddr, m_vbit, m_aaddr;
  bit         m_pol;
  logic [3:0] m_pattern;

  task automatic model_update();
    logic [7:0] old, nw, rv;
    logic [3:0] pat;
    int a, v, b, t;
    bit fire;
    if (rst) begin
      m_wprev = 0; m_rd1 = 0; m_rdata = 0; m_hits = 0; m_type = 0;
      return;
    end
    fire = 0; rv = 0;
    a = int'(address); v = m_vaddr; b = m_vbit; t = m_type;
    if (t == 7 || (t == 5 && m_aaddr == v)) t = 0;
    if (a < CAP) begin
      old = m_mem[a];
      if (write_read) begin
        nw = m_wprev;
        if ((t == 1 || t == 2) && a == v) nw[b] = (t == 2);
        if (t == 3 && a == v && old[b] == 1'b0 && nw[b] == 1'b1) nw[b] = 1'b0;
        if (t == 4 && a == v && old[b] == 1'b1 && nw[b] == 1'b0) nw[b] = 1'b1;
        if (t == 6 && a == v) begin
          pat = {(v + 1 < CAP) ? m_mem[v+1][b] : 1'b0, (v > 0) ? m_mem[v-1][b] : 1'b0,
                 old[(b + 1) % 8], old[(b + 7) % 8]};
          if (pat == m_pattern) nw[b] = m_pol;
        end
        if (nw != m_wprev) fire = 1;
        if (t == 5 && a == m_aaddr && old[b] == 1'b0 && nw[b] == 1'b1 && v < CAP) begin
          if (m_mem[v][b] != m_pol) fire = 1;
          m_mem[v][b] = m_pol;
        end
        m_mem[a] = nw;
      end else begin
        rv = old;
        if ((t == 1 || t == 2) && a == v) rv[b] = (t == 2);
        if (rv != old) fire = 1;
      end
    end
    m_rdata = m_rd1;
    if (!write_read) m_rd1 = rv;
    if (fire && m_hits < 255) m_hits++;
    m_wprev = wdata;
    if (cfg_load) begin
      m_type = int'(cfg_type); m_vaddr = int'(cfg_vaddr); m_vbit = int'(cfg_vbit);
      m_aaddr = int'(cfg_aaddr); m_pol = cfg_pol; m_pattern = cfg_pattern;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      vec++;
      if (rdata !== m_rdata) begin
        miss++;
        $display("FAIL cyc%0d rdata: got 0x%0h expected 0x%0h", cyc, rdata, m_rdata);
      end
      vec++;
      if (fault_hits !== 8'(m_hits)) begin
        miss++;
        $display("FAIL cyc%0d fault_hits: got %0d expected %0d", cyc, fault_hits, m_hits);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit ld = 1'b0);
    write_read = 1'b0; address = 6'(IDLE); wdata = d; step();
    write_read = 1'b1; address = 6'(a); cfg_load = ld; step();
    write_read = 1'b0; address = 6'(IDLE); cfg_load = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string name);
    write_read = 1'b0; address = 6'(a); step();
    address = 6'(IDLE); step();
    chk(name, rdata, exp);
  endtask

  task automatic set_cfg(input int t, input int v, input int b, input int ag,
                         input bit pol, input logic [3:0] pat, input bit load = 1'b1);
    cfg_type = 3'(t); cfg_vaddr = 6'(v); cfg_vbit = 3'(b); cfg_aaddr = 6'(ag);
    cfg_pol = pol; cfg_pattern = pat;
    if (load) begin
      cfg_load = 1'b1; step(); cfg_load = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; write_read = 1'b0; address = 6'(IDLE); wdata = 8'h00; cfg_load = 1'b0;
    cfg_type = 3'd0; cfg_vaddr = 6'd0; cfg_vbit = 3'd0; cfg_aaddr = 6'd0;
    cfg_pol = 1'b0; cfg_pattern = 4'd0;
    step(); step();
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_hits", fault_hits, 8'h00);
    rst = 1'b0;

    for (int a = 0; a < CAP; a++) wr(a, 8'(a * 5 + 3));
    step(); step();
    chk_en = 1'b1;

    // No fault
    wr(3, 8'hA5);
    rd(3, 8'hA5, "none_rd3");
    chk("none_hits", fault_hits, 8'd0);

    // SAF1 v=5 b=2
    set_cfg(2, 5, 2, 0, 1'b0, 4'd0);
    wr(5, 8'h00);
    rd(5, 8'h04, "saf1_rd5");
    chk("saf1_hits", fault_hits, 8'd1);
    wr(6, 8'h00);
    rd(6, 8'h00, "saf1_rd6");

    // TF_UP then TF_DN on v=7 b=0
    set_cfg(3, 7, 0, 0, 1'b0, 4'd0);
    wr(7, 8'h00); wr(7, 8'hFF);
    rd(7, 8'hFE, "tfup_rd7");
    set_cfg(4, 7, 0, 0, 1'b0, 4'd0);
    wr(7, 8'h00);
    rd(7, 8'h00, "tfdn_rd7_a");
    wr(7, 8'h01); wr(7, 8'h00);
    rd(7, 8'h01, "tfdn_rd7_b");

    // CFID a=2 v=9 b=1 pol=0
    set_cfg(5, 9, 1, 2, 1'b0, 4'd0);
    wr(9, 8'hFF); wr(2, 8'h00); wr(2, 8'h02);
    rd(9, 8'hFD, "cfid_rd9");
    rd(2, 8'h02, "cfid_rd2");

    // NPSF v=0 b=1 pol=1: first pattern misses, second matches
    wr(1, 8'h00); wr(0, 8'h05);
    set_cfg(6, 0, 1, 0, 1'b1, 4'b0110);
    wr(0, 8'h05);
    rd(0, 8'h05, "npsf_nohit");
    set_cfg(6, 0, 1, 0, 1'b1, 4'b0011);
    wr(0, 8'h05);
    rd(0, 8'h07, "npsf_hit");

    // NPSF at the top word with bit wrap: v+1 out of range, b+1 wraps to bit 0
    wr(46, 8'h80); wr(47, 8'h01);
    set_cfg(6, 47, 7, 0, 1'b1, 4'b0110);
    wr(47, 8'h01);
    rd(47, 8'h81, "npsf_edge");

    // Config loaded in the same cycle as a victim write: the write sees the old config
    set_cfg(1, 12, 3, 0, 1'b0, 4'd0, 1'b0);
    wr(12, 8'hFF, 1'b1);
    rd(12, 8'hF7, "saf0_rd_fault");
    set_cfg(0, 0, 0, 0, 1'b0, 4'd0);
    rd(12, 8'hFF, "saf0_same_cycle");

    // Reserved type and aggressor==victim both act as no fault
    set_cfg(7, 3, 0, 0, 1'b0, 4'd0);
    rd(3, 8'hA5, "type7_none");
    set_cfg(5, 4, 0, 4, 1'b0, 4'd0);
    wr(4, 8'h00); wr(4, 8'h01);
    rd(4, 8'h01, "cfid_self_none");

    // Out-of-range address: write dropped, read returns 0, SAF on it never fires
    set_cfg(2, 50, 0, 0, 1'b0, 4'd0);
    wr(50, 8'h33);
    rd(50, 8'h00, "oor_rd");

    // Counter saturation via repeated SAF0 reads
    set_cfg(0, 0, 0, 0, 1'b0, 4'd0);
    wr(20, 8'hFF);
    set_cfg(1, 20, 0, 0, 1'b0, 4'd0);
    write_read = 1'b0; address = 6'd20;
    repeat (260) step();
    chk("sat_hits", fault_hits, 8'hFF);
    chk("sat_rdata", rdata, 8'hFE);

    // Reset during an in-flight read with a write in the reset cycle
    write_read = 1'b0; address = 6'd3; wdata = 8'h11; step();
    rst = 1'b1; write_read = 1'b1; address = 6'd3; step();
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_hits", fault_hits, 8'h00);
    rst = 1'b0; write_read = 1'b0; address = 6'(IDLE); step();
    rd(3, 8'hA5, "rst_retain");
    rd(20, 8'hFF, "rst_cfg_none");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
